distance_mean_filter: RTL and testbench

//  Sliding-window mean filter for raw ultrasonic distance samples (mm).
//  - Sits between the echo-timing/distance-calculation stage and the buzzer/LED alarm stage.
//  - Drops out-of-range samples (timeouts, glitches) and averages the last 2**DEPTH_LOG2 valid samples.
//  - Drives the filtered 13-bit distance consumed by the alarm logic.

---
 rtl/distance_mean_filter_if.sv | 11 +
 rtl/distance_mean_filter.sv | 61 ++++++
 tb/tb_distance_mean_filter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/distance_mean_filter_if.sv
// distance_mean_filter_if: sample strobe in, filtered distance and status out
interface distance_mean_filter_if #(parameter int DATA_W = 13);
  logic [DATA_W-1:0] data_in;
  logic              data_in_valid;
  logic [DATA_W-1:0] data_ave;
  logic              data_ave_valid;
  logic              fill_done;
  logic [7:0]        reject_cnt;
  modport master(output data_in, data_in_valid, input data_ave, data_ave_valid, fill_done, reject_cnt);
  modport slave(input data_in, data_in_valid, output data_ave, data_ave_valid, fill_done, reject_cnt);
endinterface

// File: rtl/distance_mean_filter.sv
// distance_mean_filter: range-gated sliding-window mean of ultrasonic distance samples
module distance_mean_filter #(
  parameter int                DATA_W     = 13,
  parameter int                DEPTH_LOG2 = 3,
  parameter logic [DATA_W-1:0] MIN_DIST   = 20,
  parameter logic [DATA_W-1:0] MAX_DIST   = 4000
) (
  input logic sys_clk,
  input logic sys_rst,
  distance_mean_filter_if.slave bus
);
  localparam int N  = 1 << DEPTH_LOG2;
  localparam int SW = DATA_W + DEPTH_LOG2;
  typedef enum logic {FILL, RUN} state_t;
  state_t                state;
  logic [DATA_W-1:0]     buffer [N];
  logic [DEPTH_LOG2-1:0] wr_ptr, cnt;
  logic [SW-1:0]         sum;
  logic                  s1_valid, s1_pass;
  logic [DATA_W-1:0]     s1_data;
  logic                  accept, reject;
  always_comb begin
    accept = bus.data_in_valid && bus.data_in >= MIN_DIST && bus.data_in <= MAX_DIST;
    reject = bus.data_in_valid && !accept;
  end
  // Stage 1 updates window and sum; stage 2 picks pass-through sample or window mean.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state              <= FILL;
      wr_ptr             <= '0;
      cnt                <= '0;
      sum                <= '0;
      for (int i = 0; i < N; i++) buffer[i] <= '0;
      s1_valid           <= 1'b0;
      s1_pass            <= 1'b0;
      s1_data            <= '0;
      bus.data_ave       <= '1;
      bus.data_ave_valid <= 1'b0;
      bus.fill_done      <= 1'b0;
      bus.reject_cnt     <= '0;
    end else begin
      s1_valid           <= accept;
      bus.data_ave_valid <= s1_valid;
      if (s1_valid) bus.data_ave <= s1_pass ? s1_data : sum[SW-1:DEPTH_LOG2];
      if (reject && bus.reject_cnt != 8'hFF) bus.reject_cnt <= bus.reject_cnt + 8'd1;
      if (accept) begin
        buffer[wr_ptr] <= bus.data_in;
        sum            <= sum + SW'(bus.data_in) - SW'(buffer[wr_ptr]);
        wr_ptr         <= wr_ptr + 1'b1;
        s1_data        <= bus.data_in;
        s1_pass        <= state == FILL && cnt != '1;
        if (state == FILL) begin
          if (cnt == '1) begin
            state         <= RUN;
            bus.fill_done <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_distance_mean_filter.sv
// tb_distance_mean_filter: table vectors, corner sequences and random stimulus vs a window model
module tb_distance_mean_filter;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;
  distance_mean_filter_if #(.DATA_W(13)) bus();
  distance_mean_filter dut(.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus));

  typedef struct {bit rst; int din; int ave; int fill;} vec_t;
  vec_t tbl[$];
  int errors = 0, checks = 0;
  int win[$];
  int acc_cnt, rej, exp_ave, prev_d, pulses;
  bit prev_v;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    win.delete();
    acc_cnt = 0;
    rej     = 0;
    exp_ave = 8191;
    prev_v  = 0;
    prev_d  = 0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    bus.data_in_valid = 1'b0;
    bus.data_in = '0;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    model_reset();
    chk("rst_valid", int'(bus.data_ave_valid), 0);
    chk("rst_ave", int'(bus.data_ave), 8191);
    chk("rst_fill", int'(bus.fill_done), 0);
    chk("rst_rej", int'(bus.reject_cnt), 0);
  endtask

  // One clock of stimulus; the model predicts what the DUT shows after this edge.
  task automatic cyc(bit v, int d);
    bit acc;
    int nd, s;
    nd = 0;
    bus.data_in_valid = v;
    bus.data_in = 13'(d);
    acc = v && d >= 20 && d <= 4000;
    if (acc) begin
      win.push_back(d);
      if (win.size() > 8) void'(win.pop_front());
      acc_cnt++;
      if (acc_cnt < 8) nd = d;
      else begin
        s = 0;
        foreach (win[i]) s += win[i];
        nd = s / 8;
      end
    end else if (v && rej < 255) rej++;
    @(posedge sys_clk);
    #1;
    if (prev_v) exp_ave = prev_d;
    chk("valid", int'(bus.data_ave_valid), int'(prev_v));
    chk("ave", int'(bus.data_ave), exp_ave);
    chk("fill", int'(bus.fill_done), int'(acc_cnt >= 8));
    chk("rej", int'(bus.reject_cnt), rej);
    prev_v = acc;
    prev_d = nd;
    bus.data_in_valid = 1'b0;
  endtask

  initial begin
    bus.data_in = '0;
    bus.data_in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tbl.push_back('{i == 0, 1000 - 100 * i, 1000 - 100 * i, 0});
    tbl.push_back('{0, 300, 650, 1});
    for (int i = 0; i < 8; i++) tbl.push_back('{i == 0, 1000, 1000, int'(i == 7)});
    for (int i = 0; i < 8; i++) tbl.push_back('{0, 200, 900 - 100 * i, 1});

    do_reset();
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      cyc(1, tbl[i].din);
      cyc(0, 0);
      chk("tbl_ave", int'(bus.data_ave), tbl[i].ave);
      chk("tbl_fill", int'(bus.fill_done), tbl[i].fill);
    end

    cyc(1, 0);
    cyc(1, 5000);
    cyc(1, 19);
    cyc(0, 0);
    cyc(0, 0);
    chk("rej3", int'(bus.reject_cnt), 3);
    chk("rej_hold", int'(bus.data_ave), 200);
    for (int i = 0; i < 297; i++) cyc(1, (i % 2) ? 0 : 4001);
    cyc(0, 0);
    chk("rej_sat", int'(bus.reject_cnt), 255);
    cyc(1, 0);
    chk("rej_sat2", int'(bus.reject_cnt), 255);

    cyc(1, 20);
    cyc(0, 0);
    chk("min_ave", int'(bus.data_ave), 177);
    cyc(1, 4000);
    cyc(1, 0);
    chk("max_valid", int'(bus.data_ave_valid), 1);
    chk("max_ave", int'(bus.data_ave), 652);
    cyc(0, 0);

    do_reset();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 400);
      pulses += int'(bus.data_ave_valid);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0);
      pulses += int'(bus.data_ave_valid);
    end
    chk("b2b_pulses", pulses, 10);
    chk("b2b_fill", int'(bus.fill_done), 1);

    for (int i = 0; i < 8; i++) cyc(1, 1500);
    cyc(1, 700);
    do_reset();
    cyc(0, 0);
    chk("rst_flush", int'(bus.data_ave_valid), 0);
    cyc(1, 600);
    cyc(0, 0);
    chk("post_rst_ave", int'(bus.data_ave), 600);
    chk("post_rst_fill", int'(bus.fill_done), 0);

    for (int n = 0; n < 3000; n++) begin
      int r, d;
      r = int'($urandom_range(0, 9));
      d = (r == 0) ? 0 : (r == 1) ? 19 : (r == 2) ? 20 : (r == 3) ? 4000 : (r == 4) ? 4001 :
          (r == 5) ? int'($urandom_range(4001, 8191)) : int'($urandom_range(20, 4000));
      if ($urandom_range(0, 499) == 0) do_reset();
      else cyc($urandom_range(0, 3) != 0, d);
    end
    cyc(0, 0);
    cyc(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
